// File: rtl/hex_display_scanner_pkg.sv
// Shared seven-segment definitions: active-low glyphs (bit 0 = seg a) and digit-count limits.
package hex_display_scanner_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    localparam int NUM_DIGITS_MIN = 1;
    localparam int NUM_DIGITS_MAX = 8;

endpackage

// File: rtl/hex_digit_decoder.sv
// Combinational nibble-to-glyph decoder with a dark override.
module hex_digit_decoder
    import hex_display_scanner_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = SEG_BLANK;
        if (!blank_i) begin
            case (nibble_i)
                4'h0: glyph_o = GLYPH_0;
                4'h1: glyph_o = GLYPH_1;
                4'h2: glyph_o = GLYPH_2;
                4'h3: glyph_o = GLYPH_3;
                4'h4: glyph_o = GLYPH_4;
                4'h5: glyph_o = GLYPH_5;
                4'h6: glyph_o = GLYPH_6;
                4'h7: glyph_o = GLYPH_7;
                4'h8: glyph_o = GLYPH_8;
                4'h9: glyph_o = GLYPH_9;
                4'hA: glyph_o = GLYPH_A;
                4'hB: glyph_o = GLYPH_B;
                4'hC: glyph_o = GLYPH_C;
                4'hD: glyph_o = GLYPH_D;
                4'hE: glyph_o = GLYPH_E;
                4'hF: glyph_o = GLYPH_F;
                default: glyph_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Multi-digit hex display driver: shadow value, leading-zero blanking,
// static per-digit segment buses and a time-multiplexed scan output.
module hex_display_scanner
    import hex_display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    lzb_en,
    input  logic                    blank,
    output logic [7*NUM_DIGITS-1:0] seg_static,
    output logic [6:0]              seg_mux,
    output logic [NUM_DIGITS-1:0]   digit_sel
);

    localparam int PSC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PSC_W-1:0] PSC_TC   = PSC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    generate
        if (NUM_DIGITS < NUM_DIGITS_MIN || NUM_DIGITS > NUM_DIGITS_MAX) begin : g_bad_digits
            $error("hex_display_scanner: NUM_DIGITS out of range 1..8");
        end
        if (SCAN_DIV < 1) begin : g_bad_div
            $error("hex_display_scanner: SCAN_DIV must be >= 1");
        end
    endgenerate

    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [PSC_W-1:0]        psc_q, psc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [7*NUM_DIGITS-1:0] seg_static_q, seg_static_d;
    logic [6:0]              seg_mux_q, seg_mux_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;

    logic [NUM_DIGITS-1:0]   dark;
    logic [7*NUM_DIGITS-1:0] glyph_w;
    logic                    zero_run;

    // Walk from the MS digit down; a digit is a leading zero while every digit above it is zero too.
    always_comb begin
        dark     = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (value_q[4*i +: 4] == 4'h0);
            dark[i]  = blank | (lzb_en & zero_run & (i != 0));
        end
    end

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
            hex_digit_decoder u_dec (
                .nibble_i (value_q[4*g +: 4]),
                .blank_i  (dark[g]),
                .glyph_o  (glyph_w[7*g +: 7])
            );
        end
    endgenerate

    always_comb begin
        value_d      = load ? value : value_q;
        psc_d        = (psc_q == PSC_TC) ? '0 : psc_q + PSC_W'(1);
        idx_d        = idx_q;
        if (psc_q == PSC_TC) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        seg_static_d = glyph_w;
        // Glyph and select come from the same index on the same edge, so no ghosting.
        seg_mux_d    = glyph_w[7*idx_q +: 7];
        digit_sel_d  = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q      <= '0;
            psc_q        <= '0;
            idx_q        <= '0;
            seg_static_q <= '1;
            seg_mux_q    <= SEG_BLANK;
            digit_sel_q  <= '1;
        end else begin
            value_q      <= value_d;
            psc_q        <= psc_d;
            idx_q        <= idx_d;
            seg_static_q <= seg_static_d;
            seg_mux_q    <= seg_mux_d;
            digit_sel_q  <= digit_sel_d;
        end
    end

    assign seg_static = seg_static_q;
    assign seg_mux    = seg_mux_q;
    assign digit_sel  = digit_sel_q;

endmodule
